// File: rtl/de_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : de_pipe_stage
// Description : Elastic Decode->Execute pipeline register with valid/ready
//               handshake, 2-entry skid buffer (main + skid), flush-to-bubble
//               and synchronous active-high reset.
//               Optional statistics counters are enabled by defining the
//               macro DE_PIPE_STATS_EN (adds stall_cnt / flush_cnt ports).
// Revision    : 1.0 - initial release
// ============================================================================
module de_pipe_stage #(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int FUNC_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] controlSignals_in,
  input  logic [DATA_W-1:0] readData1_in,
  input  logic [DATA_W-1:0] readData2_in,
  input  logic [ADDR_W-1:0] writeAdd_in,
  input  logic [FUNC_W-1:0] function_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] controlSignals_out,
  output logic [DATA_W-1:0] readData1_out,
  output logic [DATA_W-1:0] readData2_out,
  output logic [ADDR_W-1:0] writeAdd_out,
  output logic [FUNC_W-1:0] function_out
`ifdef DE_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int ENTRY_W = CTRL_W + 2*DATA_W + ADDR_W + FUNC_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   main_q;
  logic [ENTRY_W-1:0]   skid_q;
  logic [ENTRY_W-1:0]   in_entry;
  logic                 accept;
  logic                 pop;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;

  // Handshake flags come straight from the registered state so no
  // combinational path exists from in_valid or out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_entry = {controlSignals_in, readData1_in, readData2_in,
                     writeAdd_in, function_in};

  // Next-state and load-select decode; flush overrides normal operation.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry storage; entries only change on an explicit load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  // Control bundle becomes a NOP bubble whenever no valid entry is held.
  assign controlSignals_out = out_valid ? main_q[ENTRY_W-1 -: CTRL_W] : '0;
  assign readData1_out      = main_q[ENTRY_W-CTRL_W-1 -: DATA_W];
  assign readData2_out      = main_q[ADDR_W+FUNC_W+DATA_W-1 -: DATA_W];
  assign writeAdd_out       = main_q[ADDR_W+FUNC_W-1 -: ADDR_W];
  assign function_out       = main_q[FUNC_W-1:0];

`ifdef DE_PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [1:0]       held_cnt;
  logic [1:0]       drop_cnt;
  logic [CNT_W:0]   flush_sum;

  // Entries held at a flush, minus one already consumed by Execute, plus
  // the entry being presented (which is dropped).
  always_comb begin
    held_cnt = 2'd0;
    case (state_q)
      ONE:     held_cnt = 2'd1;
      FULL:    held_cnt = 2'd2;
      default: held_cnt = 2'd0;
    endcase
    drop_cnt  = held_cnt - {1'b0, pop} + {1'b0, in_valid};
    flush_sum = {1'b0, flush_cnt_q} + (CNT_W+1)'(drop_cnt);
  end

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush) begin
        flush_cnt_q <= flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_de_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_de_pipe_stage
// Description : Self-checking bench for de_pipe_stage using an entry
//               scoreboard queue and an occupancy/statistics model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_de_pipe_stage;

  localparam int CTRL_W = 13;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int FUNC_W = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] controlSignals_in;
  logic [DATA_W-1:0] readData1_in;
  logic [DATA_W-1:0] readData2_in;
  logic [ADDR_W-1:0] writeAdd_in;
  logic [FUNC_W-1:0] function_in;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] controlSignals_out;
  logic [DATA_W-1:0] readData1_out;
  logic [DATA_W-1:0] readData2_out;
  logic [ADDR_W-1:0] writeAdd_out;
  logic [FUNC_W-1:0] function_out;
`ifdef DE_PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  de_pipe_stage #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .FUNC_W (FUNC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .controlSignals_in  (controlSignals_in),
    .readData1_in       (readData1_in),
    .readData2_in       (readData2_in),
    .writeAdd_in        (writeAdd_in),
    .function_in        (function_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .controlSignals_out (controlSignals_out),
    .readData1_out      (readData1_out),
    .readData2_out      (readData2_out),
    .writeAdd_out       (writeAdd_out),
    .function_out       (function_out)
`ifdef DE_PIPE_STATS_EN
    ,
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of entries expected on the outputs, oldest first.
  logic [63:0] sb[$];
  int          stall_m = 0;
  int          flush_m = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_entry(input logic [12:0] c, input logic [15:0] d);
    logic [15:0] d2;
    d2 = d ^ 16'hA5A5;
    return {12'h0, c, d, d2, d[2:0], d[7:4]};
  endfunction

  function automatic logic [63:0] obs_entry();
    return {12'h0, controlSignals_out, readData1_out, readData2_out, writeAdd_out, function_out};
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by what the edge will do.
  task automatic step(input logic vin, input logic [15:0] d, input logic [12:0] c,
                      input logic ordy, input logic fl, input logic rs);
    logic acc, pp;
    int   n;
    rst               = rs;
    flush             = fl;
    in_valid          = vin;
    controlSignals_in = c;
    readData1_in      = d;
    readData2_in      = d ^ 16'hA5A5;
    writeAdd_in       = d[2:0];
    function_in       = d[7:4];
    out_ready         = ordy;
    #1;
    check("in_ready", {63'h0, in_ready}, {63'h0, (sb.size() != 2)});
    check("out_valid", {63'h0, out_valid}, {63'h0, (sb.size() != 0)});
    if (sb.size() != 0) check("entry", obs_entry(), sb[0]);
    else check("bubble_ctrl", {51'h0, controlSignals_out}, 64'h0);
`ifdef DE_PIPE_STATS_EN
    check("stall_cnt", {60'h0, stall_cnt}, 64'(stall_m));
    check("flush_cnt", {60'h0, flush_cnt}, 64'(flush_m));
`endif
    acc = vin && (sb.size() < 2);
    pp  = (sb.size() != 0) && ordy;
    if (rs) begin
      sb.delete();
      stall_m = 0;
      flush_m = 0;
    end else begin
      if ((sb.size() != 0) && !ordy && stall_m < CNT_MAX) stall_m++;
      if (fl) begin
        n = sb.size() - (pp ? 1 : 0) + (vin ? 1 : 0);
        flush_m = (flush_m + n > CNT_MAX) ? CNT_MAX : flush_m + n;
        sb.delete();
      end else begin
        if (pp) void'(sb.pop_front());
        if (acc) sb.push_back(mk_entry(c, d));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset held for two edges while an entry is presented.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; controlSignals_in = 13'h1FFF;
    readData1_in = 16'hFFFF; readData2_in = 16'hFFFF;
    writeAdd_in = 3'h7; function_in = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check("rst_outputs", obs_entry(), 64'h0);
`ifdef DE_PIPE_STATS_EN
    check("rst_stall", {60'h0, stall_cnt}, 64'h0);
    check("rst_flush", {60'h0, flush_cnt}, 64'h0);
`endif
    @(negedge clk);

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 13'h0101, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);

    // Stall: A and B absorbed, third offer refused, then drain.
    step(1'b1, 16'h00AA, 13'h0AAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00BB, 13'h0BBB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00CC, 13'h0CCC, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with C presented; C must never appear.
    step(1'b1, 16'h0011, 13'h0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 13'h0022, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00C0, 13'h1C0C, 1'b0, 1'b1, 1'b0);
`ifdef DE_PIPE_STATS_EN
    check("flush_full_cnt", {60'h0, flush_cnt}, 64'd3);
`endif
    repeat (2) step(1'b0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);

    // Simultaneous accept and pop in ONE.
    step(1'b1, 16'h00DD, 13'h0DDD, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00EE, 13'h0EEE, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 13'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b0);
    end

    // Long stall to reach counter saturation.
    step(1'b1, 16'h0055, 13'h0555, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0066, 13'h0666, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
`ifdef DE_PIPE_STATS_EN
    check("stall_sat", {60'h0, stall_cnt}, 64'd15);
`endif

    // Reset together with flush and an offered entry.
    step(1'b1, 16'h0077, 13'h0777, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    check("rst2_outputs", obs_entry(), 64'h0);
    step(1'b1, 16'h0088, 13'h0888, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
